// File: rtl/sobel_pkg.sv
// Shared types and constants for the 3x3 Sobel edge stage.
//   SOBEL_LAT : cycles from an accepted pixel to its oEDGE beat
//   PIX_W     : pixel width (line-buffer tap width)
//   GW        : signed gradient width; 4*(2^PIX_W-1) must fit as a positive value
//   PIX_MAX   : largest representable pixel value, used for saturation
package sobel_pkg;

  localparam int unsigned SOBEL_LAT = 3;
  localparam int unsigned PIX_W     = 10;
  localparam int unsigned GW        = 13;
  localparam int unsigned PIX_MAX   = (1 << PIX_W) - 1;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [GW-1:0]    grad_t;
  typedef logic        [GW-1:0]    mag_t;

endpackage

// File: rtl/sobel_kernel.sv
// Sobel gradient and magnitude datapath (pipeline stages S2 and S3).
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   win_i        : 3x3 window, win_i[row][col], row 0 = top, col 0 = oldest
//   border_i     : window incomplete; forces the output to 0
//   valid_i      : S1 valid, carried alongside the data
//   thresh_i     : edge threshold (only used when SOBEL_THRESH_EN is defined)
//   edge_o       : saturated |Gx|+|Gy|, or binary all-ones/0 edge with SOBEL_THRESH_EN
//   valid_o      : edge_o qualifier
// Optional feature macro: SOBEL_THRESH_EN.
module sobel_kernel
  import sobel_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  pix_t [2:0][2:0]     win_i,
  input  logic                border_i,
  input  logic                valid_i,
  input  pix_t                thresh_i,
  output pix_t                edge_o,
  output logic                valid_o
);

  grad_t gx_q, gx_d;
  grad_t gy_q, gy_d;
  logic  border2_q;
  logic  v2_q;
  pix_t  edge_q, edge_d;
  mag_t  mag;
  pix_t  mag_sat;

  function automatic grad_t ext(input pix_t p);
    return grad_t'({{(GW-PIX_W){1'b0}}, p});
  endfunction

  function automatic mag_t absg(input grad_t g);
    grad_t n;
    n = -g;
    return g[GW-1] ? mag_t'(n) : mag_t'(g);
  endfunction

  // S2: signed column/row differences with [1 2 1] smoothing
  always_comb begin
    gx_d = (ext(win_i[0][2]) + (ext(win_i[1][2]) <<< 1) + ext(win_i[2][2]))
         - (ext(win_i[0][0]) + (ext(win_i[1][0]) <<< 1) + ext(win_i[2][0]));
    gy_d = (ext(win_i[2][0]) + (ext(win_i[2][1]) <<< 1) + ext(win_i[2][2]))
         - (ext(win_i[0][0]) + (ext(win_i[0][1]) <<< 1) + ext(win_i[0][2]));
  end

  // S3: L1 magnitude (max 8184 fits GW unsigned bits), saturated to pixel range
  always_comb begin
    mag     = absg(gx_q) + absg(gy_q);
    mag_sat = (mag > mag_t'(PIX_MAX)) ? pix_t'(PIX_MAX) : mag[PIX_W-1:0];
    edge_d  = '0;
    if (!border2_q) begin
`ifdef SOBEL_THRESH_EN
      edge_d = (mag_sat > thresh_i) ? '1 : '0;
`else
      edge_d = mag_sat;
`endif
    end
  end

`ifndef SOBEL_THRESH_EN
  // Threshold port is kept for a uniform interface; value ignored in this build.
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q      <= '0;
      gy_q      <= '0;
      border2_q <= 1'b0;
      v2_q      <= 1'b0;
      edge_q    <= '0;
      valid_o   <= 1'b0;
    end else begin
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      border2_q <= border_i;
      v2_q      <= valid_i;
      edge_q    <= edge_d;
      valid_o   <= v2_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/sobel_window_3x3.sv
// 3x3 window assembly and Sobel edge magnitude, downstream of the line buffer.
//   VGA_CLK      : pixel clock (same as line-buffer reads)
//   iRST_N       : asynchronous active-low reset
//   iFRAME_START : one-cycle pulse before a frame's first line; clears the line count
//   READ_Request : pixel valid, high across the active part of each line
//   iPIX         : current-line pixel (bottom window row)
//   taps0x       : previous line (middle window row)
//   taps1x       : line before previous (top window row)
//   iTHRESH      : edge threshold (only used when SOBEL_THRESH_EN is defined)
//   oEDGE        : edge value, 3 cycles after its accepted pixel
//   oVALID       : READ_Request delayed 3 cycles
// Optional feature macro: SOBEL_THRESH_EN (binary thresholded output).
// DW must equal sobel_pkg::PIX_W.
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int DW = 10,
  parameter int XW = 13,
  parameter int YW = 11
) (
  input  logic          VGA_CLK,
  input  logic          iRST_N,
  input  logic          iFRAME_START,
  input  logic          READ_Request,
  input  logic [DW-1:0] iPIX,
  input  logic [DW-1:0] taps0x,
  input  logic [DW-1:0] taps1x,
  input  logic [DW-1:0] iTHRESH,
  output logic [DW-1:0] oEDGE,
  output logic          oVALID
);

  pix_t [2:0][2:0] win_q, win_d;   // [row][col], col 2 = newest
  logic            rr_q;
  logic            fall;
  logic [XW-1:0]   col_q, col_d;
  logic [YW-1:0]   row_q, row_d;
  logic            border_q, border_d;
  logic            v1_q;

  assign fall = rr_q & ~READ_Request;

  always_comb begin
    win_d = win_q;
    if (READ_Request) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = taps1x;
      win_d[1][2] = taps0x;
      win_d[2][2] = iPIX;
    end
  end

  always_comb begin
    col_d = col_q;
    if (READ_Request) begin
      if (col_q != '1) col_d = col_q + XW'(1);
    end else if (fall) begin
      col_d = '0;
    end
  end

  // Frame start takes priority over a coincident end-of-line increment.
  always_comb begin
    row_d = row_q;
    if (iFRAME_START) begin
      row_d = '0;
    end else if (fall && (row_q != '1)) begin
      row_d = row_q + YW'(1);
    end
  end

  // Uses pre-increment counters: the window ending at this pixel is complete
  // only once two earlier columns and two earlier lines exist.
  assign border_d = (col_q < XW'(2)) || (row_q < YW'(2));

  always_ff @(posedge VGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      win_q    <= '0;
      rr_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      border_q <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      win_q    <= win_d;
      rr_q     <= READ_Request;
      col_q    <= col_d;
      row_q    <= row_d;
      border_q <= border_d;
      v1_q     <= READ_Request;
    end
  end

  sobel_kernel u_kernel (
    .clk      (VGA_CLK),
    .rst_n    (iRST_N),
    .win_i    (win_q),
    .border_i (border_q),
    .valid_i  (v1_q),
    .thresh_i (iTHRESH),
    .edge_o   (oEDGE),
    .valid_o  (oVALID)
  );

endmodule

// File: tb/tb_sobel_window_3x3.sv
module tb_sobel_window_3x3;

  localparam int DW = 10;
  localparam int XW = 13;
  localparam int YW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fs;
  logic          rr;
  logic [DW-1:0] pix, t0, t1, thr;
  logic [DW-1:0] dut_edge;
  logic          vld;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_window_3x3 #(.DW(DW), .XW(XW), .YW(YW)) dut (
    .VGA_CLK      (clk),
    .iRST_N       (rst_n),
    .iFRAME_START (fs),
    .READ_Request (rr),
    .iPIX         (pix),
    .taps0x       (t0),
    .taps1x       (t1),
    .iTHRESH      (thr),
    .oEDGE        (dut_edge),
    .oVALID       (vld)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_row = 0;
  int   lt1[$];
  int   lt0[$];
  int   lb[$];

  // Reference: window ending at column c of the current line, rows from the three taps.
  function automatic int expect_at(input int c, input int r);
    int gx, gy, m;
    if (c < 2 || r < 2) return 0;
    gx = (lt1[c] + 2*lt0[c] + lb[c]) - (lt1[c-2] + 2*lt0[c-2] + lb[c-2]);
    gy = (lb[c-2] + 2*lb[c-1] + lb[c]) - (lt1[c-2] + 2*lt1[c-1] + lt1[c]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 1023) m = 1023;
`ifdef SOBEL_THRESH_EN
    m = (m > int'(thr)) ? 1023 : 0;
`endif
    return m;
  endfunction

  // mode: 0 flat 512, 1 vertical step at col 8, 2 top 0 / bottom 1023, else random
  task automatic drive_pixels(input int n, input int mode);
    int a, b, d;
    lt1.delete(); lt0.delete(); lb.delete();
    for (int c = 0; c < n; c++) begin
      case (mode)
        0: begin a = 512; b = 512; d = 512; end
        1: begin a = (c >= 8) ? 100 : 0; b = a; d = a; end
        2: begin a = 0; b = 500; d = 1023; end
        default: begin
          a = $urandom_range(0, 1023);
          b = $urandom_range(0, 1023);
          d = $urandom_range(0, 1023);
        end
      endcase
      lt1.push_back(a); lt0.push_back(b); lb.push_back(d);
      @(posedge clk); #1;
      rr  = 1'b1;
      t1  = DW'(a);
      t0  = DW'(b);
      pix = DW'(d);
      sb.push_back('{expect_at(c, model_row), cyc + 3});
    end
  endtask

  task automatic send_line(input int n, input int mode, input bit fs_end, input int gap);
    drive_pixels(n, mode);
    @(posedge clk); #1;
    rr  = 1'b0;
    fs  = fs_end;
    pix = DW'($urandom_range(0, 1023));
    t0  = DW'($urandom_range(0, 1023));
    t1  = DW'($urandom_range(0, 1023));
    model_row = fs_end ? 0 : ((model_row < 2047) ? model_row + 1 : model_row);
    @(posedge clk); #1;
    fs = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    model_row = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (vld !== 1'b0 || dut_edge !== '0) begin
      n_err++;
      $display("FAIL %s: oVALID=%b oEDGE=%0d, required oVALID=0 oEDGE=0", name, vld, dut_edge);
    end
  endtask

  // Monitor: every oVALID beat must match the scoreboard head at exactly its due cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (e.due != cyc || vld !== 1'b1) begin
          n_err++;
          $display("FAIL valid_timing: cycle %0d oVALID=%b, required 1 at cycle %0d", cyc, vld, e.due);
        end else if ($isunknown(dut_edge) || int'(dut_edge) != e.val) begin
          n_err++;
          $display("FAIL edge_value: cycle %0d oEDGE=%0d, required %0d", cyc, dut_edge, e.val);
        end
      end else if (vld === 1'b1) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: cycle %0d oVALID=1 with no pixel due", cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; fs = 1'b0; rr = 1'b0;
    pix = '0; t0 = '0; t1 = '0; thr = DW'(300);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    #2 rst_n = 1'b1;

    // flat field
    frame_start();
    repeat (3) send_line(16, 0, 1'b0, 2);

    // vertical step, threshold 300
    frame_start();
    repeat (3) send_line(16, 1, 1'b0, 2);

    // vertical step, threshold 400 (strict compare)
    thr = DW'(400);
    frame_start();
    repeat (3) send_line(16, 1, 1'b0, 2);

    // saturation
    thr = DW'(300);
    frame_start();
    repeat (3) send_line(16, 2, 1'b0, 2);

    // random frame
    thr = DW'($urandom_range(0, 1023));
    frame_start();
    for (int i = 0; i < 6; i++)
      send_line($urandom_range(1, 40), 3, 1'b0, $urandom_range(1, 4));

    // frame start coincident with end-of-line: next lines restart at row 0
    send_line(20, 3, 1'b1, 2);
    for (int i = 0; i < 3; i++)
      send_line($urandom_range(3, 30), 3, 1'b0, $urandom_range(1, 3));

    // reset in the middle of a line
    drive_pixels(8, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("reset_midline");
    rr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    model_row = 0;
    for (int i = 0; i < 4; i++)
      send_line($urandom_range(3, 30), 3, 1'b0, 2);

    repeat (10) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected beats never presented, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
